// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET1,
    ST_GET2,
    ST_WRITE,
    ST_DRAIN,
    ST_CORE_RST,
    ST_DONE
  } state_e;

  // RISC-V "addi x0, x0, 0", used to pad an odd trailing word
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int DEF_ADDR_STEP   = 8;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_RST_CYCLES  = 1;

endpackage

// File: rtl/imem_stream_loader.sv
// Streams instruction words into the core's external-memory load port in pairs,
// then pulses the core reset so execution starts from address 0.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W      = 9,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_STEP   = DEF_ADDR_STEP,
  parameter int                HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int                RST_CYCLES  = DEF_RST_CYCLES,
  parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(imem_loader_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              enable_load_ex_mem,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [DATA_W-1:0] InstExMemData1,
  output logic [DATA_W-1:0] InstExMemData2,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int CNT_MAX = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RST_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  // Base address of the final pair slot; writing here ends the address space
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'((2 ** ADDR_W) - ADDR_STEP);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_seen_q, last_seen_d;
  logic              overflow_q, overflow_d;
  logic              xfer;

  assign in_ready = (state_q == ST_GET1) || (state_q == ST_GET2) || (state_q == ST_DRAIN);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    cnt_d       = cnt_q;
    last_seen_d = last_seen_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_GET1;
          addr_d     = '0;
          overflow_d = 1'b0;
        end
      end

      ST_GET1: begin
        if (xfer) begin
          data1_d     = in_data;
          last_seen_d = in_last;
          if (in_last) begin
            data2_d = NOP_WORD;
            cnt_d   = HOLD_LOAD;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_GET2;
          end
        end
      end

      ST_GET2: begin
        if (xfer) begin
          data2_d     = in_data;
          last_seen_d = in_last;
          cnt_d       = HOLD_LOAD;
          state_d     = ST_WRITE;
        end
      end

      // The same down-counter times the write hold and the core reset pulse
      ST_WRITE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (last_seen_q) begin
          cnt_d   = RST_LOAD;
          state_d = ST_CORE_RST;
        end else if (addr_q == ADDR_LAST) begin
          overflow_d = 1'b1;
          state_d    = ST_DRAIN;
        end else begin
          addr_d  = addr_q + STEP;
          state_d = ST_GET1;
        end
      end

      ST_DRAIN: begin
        if (xfer && in_last) begin
          state_d = ST_DONE;
        end
      end

      ST_CORE_RST: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      overflow_q  <= overflow_d;
    end
  end

  assign enable_load_ex_mem = (state_q == ST_WRITE);
  assign core_reset         = (state_q == ST_CORE_RST);
  assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done               = (state_q == ST_DONE);
  assign overflow           = overflow_q;
  assign InstExMemAddress   = addr_q;
  assign InstExMemData1     = data1_q;
  assign InstExMemData2     = data2_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: records every write burst seen on the
// load port and compares it against hand-computed pair/address sequences.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        enable_load_ex_mem;
  logic [8:0]  InstExMemAddress;
  logic [31:0] InstExMemData1;
  logic [31:0] InstExMemData2;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog [256];

  logic        prev_en = 1'b0;
  logic        prev_cr = 1'b0;
  int          wr_count = 0;
  logic [8:0]  wr_addr [512];
  logic [31:0] wr_d1 [512];
  logic [31:0] wr_d2 [512];
  int          wr_hold [512];
  int          stable_err = 0;
  int          ready_err = 0;
  int          rst_pulses = 0;
  int          rst_len = 0;

  imem_stream_loader dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .in_last            (in_last),
    .enable_load_ex_mem (enable_load_ex_mem),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .core_reset         (core_reset),
    .busy               (busy),
    .done               (done),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  // Write-burst recorder: one entry per rising edge of enable, with hold length
  initial begin
    forever begin
      @(negedge clk);
      if (enable_load_ex_mem === 1'b1) begin
        if (in_ready !== 1'b0) ready_err++;
        if (!prev_en) begin
          if (wr_count < 512) begin
            wr_addr[wr_count] = InstExMemAddress;
            wr_d1[wr_count]   = InstExMemData1;
            wr_d2[wr_count]   = InstExMemData2;
            wr_hold[wr_count] = 1;
          end
          wr_count++;
        end else if (wr_count > 0 && wr_count <= 512) begin
          wr_hold[wr_count-1]++;
          if (InstExMemAddress !== wr_addr[wr_count-1] ||
              InstExMemData1 !== wr_d1[wr_count-1] ||
              InstExMemData2 !== wr_d2[wr_count-1]) stable_err++;
        end
      end
      if (core_reset === 1'b1) begin
        if (!prev_cr) begin
          rst_pulses++;
          rst_len = 1;
        end else begin
          rst_len++;
        end
      end
      prev_en = (enable_load_ex_mem === 1'b1);
      prev_cr = (core_reset === 1'b1);
    end
  end

  task automatic load_prog8();
    prog[0] = 32'h0010_0393; prog[1] = 32'h0040_0113;
    prog[2] = 32'h0001_0233; prog[3] = 32'h0003_8303;
    prog[4] = 32'h0002_0333; prog[5] = 32'h0003_0383;
    prog[6] = 32'h0003_1403; prog[7] = 32'h0003_2483;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents prog[0..n-1]; gaps deassert valid every third cycle with junk data
  task automatic send_words(input int n, input bit last_at_end, input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      if (gaps && ((cyc * 5 + 1) % 3 == 0)) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b1;
      end else begin
        in_valid = 1'b1;
        in_data  = prog[idx];
        in_last  = last_at_end && (idx == n - 1);
        if (in_ready === 1'b1) idx++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    n_checks++;
    if (idx != n) begin
      n_fail++;
      $display("[TB] FAIL stream_accept: accepted %0d words, required %0d", idx, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, enable_load_ex_mem, core_reset, busy, done, overflow} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b, required 000000",
               {in_ready, enable_load_ex_mem, core_reset, busy, done, overflow});
    end
    n_checks++;
    if ({InstExMemAddress, InstExMemData1, InstExMemData2} !== 73'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: addr=%h d1=%h d2=%h, required all 0",
               InstExMemAddress, InstExMemData1, InstExMemData2);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_no_accept: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_even_program();
    int base = wr_count;
    int rp = rst_pulses;
    int se = stable_err;
    load_prog8();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL even_busy: busy=%b, required 1", busy);
    end
    send_words(8, 1'b1, 1'b0);
    wait_done(200);
    n_checks++;
    if (wr_count - base != 4) begin
      n_fail++;
      $display("[TB] FAIL even_count: %0d writes, required 4", wr_count - base);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_addr[base+k] !== 9'(8 * k) || wr_d1[base+k] !== prog[2*k] ||
          wr_d2[base+k] !== prog[2*k+1] || wr_hold[base+k] != 2) begin
        n_fail++;
        $display("[TB] FAIL even_wr%0d: got %h/%h/%h hold %0d, required %h/%h/%h hold 2",
                 k, wr_addr[base+k], wr_d1[base+k], wr_d2[base+k], wr_hold[base+k],
                 9'(8 * k), prog[2*k], prog[2*k+1]);
      end
    end
    n_checks++;
    if (rst_pulses - rp != 1 || rst_len != 1) begin
      n_fail++;
      $display("[TB] FAIL even_core_rst: %0d pulses len %0d, required 1 len 1",
               rst_pulses - rp, rst_len);
    end
    n_checks++;
    if ({done, overflow, busy} !== 3'b100 || stable_err != se) begin
      n_fail++;
      $display("[TB] FAIL even_final: done/ovf/busy=%b unstable=%0d, required 100 0",
               {done, overflow, busy}, stable_err - se);
    end
  endtask

  task automatic test_odd_program();
    int base = wr_count;
    prog[0] = 32'h1111_0001; prog[1] = 32'h2222_0002; prog[2] = 32'h3333_0003;
    pulse_start();
    send_words(3, 1'b1, 1'b0);
    wait_done(200);
    n_checks++;
    if (wr_count - base != 2) begin
      n_fail++;
      $display("[TB] FAIL odd_count: %0d writes, required 2", wr_count - base);
    end
    n_checks++;
    if (wr_addr[base] !== 9'h000 || wr_d1[base] !== 32'h1111_0001 || wr_d2[base] !== 32'h2222_0002) begin
      n_fail++;
      $display("[TB] FAIL odd_wr0: got %h/%h/%h, required 000/11110001/22220002",
               wr_addr[base], wr_d1[base], wr_d2[base]);
    end
    n_checks++;
    if (wr_addr[base+1] !== 9'h008 || wr_d1[base+1] !== 32'h3333_0003 || wr_d2[base+1] !== 32'h0000_0013) begin
      n_fail++;
      $display("[TB] FAIL odd_wr1_pad: got %h/%h/%h, required 008/33330003/00000013",
               wr_addr[base+1], wr_d1[base+1], wr_d2[base+1]);
    end
  endtask

  task automatic test_valid_gaps();
    int base = wr_count;
    int re = ready_err;
    load_prog8();
    pulse_start();
    send_words(8, 1'b1, 1'b1);
    wait_done(400);
    n_checks++;
    if (wr_count - base != 4) begin
      n_fail++;
      $display("[TB] FAIL gaps_count: %0d writes, required 4", wr_count - base);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_addr[base+k] !== 9'(8 * k) || wr_d1[base+k] !== prog[2*k] || wr_d2[base+k] !== prog[2*k+1]) begin
        n_fail++;
        $display("[TB] FAIL gaps_wr%0d: got %h/%h/%h, required %h/%h/%h", k,
                 wr_addr[base+k], wr_d1[base+k], wr_d2[base+k], 9'(8 * k), prog[2*k], prog[2*k+1]);
      end
    end
    n_checks++;
    if (ready_err != re) begin
      n_fail++;
      $display("[TB] FAIL gaps_ready_in_write: %0d cycles with in_ready=1, required 0", ready_err - re);
    end
  endtask

  task automatic test_overflow();
    int base = wr_count;
    int rp = rst_pulses;
    for (int i = 0; i < 130; i++) prog[i] = 32'hA000_0000 + 32'(i);
    pulse_start();
    send_words(130, 1'b1, 1'b0);
    wait_done(2000);
    n_checks++;
    if (wr_count - base != 64) begin
      n_fail++;
      $display("[TB] FAIL ovf_count: %0d writes, required 64", wr_count - base);
    end
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (wr_addr[base+k] !== 9'(8 * k) || wr_d1[base+k] !== prog[2*k] || wr_d2[base+k] !== prog[2*k+1]) begin
        n_fail++;
        $display("[TB] FAIL ovf_wr%0d: got %h/%h/%h, required %h/%h/%h", k,
                 wr_addr[base+k], wr_d1[base+k], wr_d2[base+k], 9'(8 * k), prog[2*k], prog[2*k+1]);
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || done !== 1'b1 || rst_pulses != rp) begin
      n_fail++;
      $display("[TB] FAIL ovf_final: overflow=%b done=%b core_rst pulses=%0d, required 1 1 0",
               overflow, done, rst_pulses - rp);
    end
    n_checks++;
    if (InstExMemAddress !== 9'h1F8) begin
      n_fail++;
      $display("[TB] FAIL ovf_no_wrap: addr=%h, required 1f8", InstExMemAddress);
    end
  endtask

  task automatic test_restart_from_done();
    int base = wr_count;
    pulse_start();
    n_checks++;
    if ({done, overflow, busy} !== 3'b001 || InstExMemAddress !== 9'h000) begin
      n_fail++;
      $display("[TB] FAIL restart_clear: done/ovf/busy=%b addr=%h, required 001 000",
               {done, overflow, busy}, InstExMemAddress);
    end
    prog[0] = 32'h5555_0005; prog[1] = 32'h6666_0006; prog[2] = 32'h7777_0007;
    send_words(3, 1'b1, 1'b0);
    wait_done(200);
    n_checks++;
    if (wr_count - base != 2 || wr_addr[base] !== 9'h000 || wr_d1[base] !== 32'h5555_0005) begin
      n_fail++;
      $display("[TB] FAIL restart_reload: %0d writes first %h/%h, required 2 000/55550005",
               wr_count - base, wr_addr[base], wr_d1[base]);
    end
  endtask

  task automatic test_start_during_write();
    int base = wr_count;
    int seen = 0;
    load_prog8();
    pulse_start();
    fork
      send_words(8, 1'b1, 1'b0);
      begin
        for (int c = 0; c < 100 && seen == 0; c++) begin
          @(negedge clk);
          if (enable_load_ex_mem === 1'b1) seen = 1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done(200);
    n_checks++;
    if (seen != 1 || wr_count - base != 4) begin
      n_fail++;
      $display("[TB] FAIL sdw_count: write seen=%0d writes=%0d, required 1 4", seen, wr_count - base);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_addr[base+k] !== 9'(8 * k) || wr_d1[base+k] !== prog[2*k] || wr_d2[base+k] !== prog[2*k+1]) begin
        n_fail++;
        $display("[TB] FAIL sdw_wr%0d: got %h/%h/%h, required %h/%h/%h", k,
                 wr_addr[base+k], wr_d1[base+k], wr_d2[base+k], 9'(8 * k), prog[2*k], prog[2*k+1]);
      end
    end
  endtask

  task automatic test_reset_mid_get2();
    int base = wr_count;
    int n_before;
    prog[0] = 32'hC000_0000; prog[1] = 32'hC000_0001; prog[2] = 32'hC000_0002;
    pulse_start();
    send_words(3, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1 || InstExMemAddress !== 9'h008 || InstExMemData1 !== 32'hC000_0002) begin
      n_fail++;
      $display("[TB] FAIL mid_setup: in_ready=%b addr=%h d1=%h, required 1 008 c0000002",
               in_ready, InstExMemAddress, InstExMemData1);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, enable_load_ex_mem, core_reset, busy, done, overflow,
         InstExMemAddress, InstExMemData1, InstExMemData2} !== 79'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_zero: flags=%b addr=%h d1=%h d2=%h, required all 0",
               {in_ready, enable_load_ex_mem, core_reset, busy, done, overflow},
               InstExMemAddress, InstExMemData1, InstExMemData2);
    end
    n_before = wr_count - base;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if (n_before != 1 || wr_count - base != 1) begin
      n_fail++;
      $display("[TB] FAIL mid_partial: %0d writes, required 1", wr_count - base);
    end
    base = wr_count;
    load_prog8();
    pulse_start();
    send_words(8, 1'b1, 1'b0);
    wait_done(200);
    n_checks++;
    if (wr_count - base != 4 || wr_addr[base] !== 9'h000 || wr_addr[base+3] !== 9'h018 ||
        wr_d2[base+3] !== 32'h0003_2483) begin
      n_fail++;
      $display("[TB] FAIL mid_reload: %0d writes first %h last %h/%h, required 4 000 018/00032483",
               wr_count - base, wr_addr[base], wr_addr[base+3], wr_d2[base+3]);
    end
  endtask

  initial begin
    test_reset();
    test_even_program();
    test_odd_program();
    test_valid_gaps();
    test_overflow();
    test_restart_from_done();
    test_start_during_write();
    test_reset_mid_get2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Hardware replacement for bench-driven instruction preload.
- Accepts a 32-bit instruction word stream on a valid/ready handshake and pairs consecutive words into Data1/Data2.
- Drives the core's external-memory load port (enable_load_ex_mem, InstExMemAddress, InstExMemData1/2), stepping the address by 8 per pair.
- Pulses the core reset after the last write so the core starts fetching from address 0.

Parameters:
- ADDR_W, 9: width of InstExMemAddress (byte address).
- DATA_W, 32: instruction word width.
- ADDR_STEP, 8: address increment per written pair.
- HOLD_CYCLES, 2: cycles each write is held with enable asserted; must be >= 1.
- RST_CYCLES, 1: length of the core_reset pulse after the load; must be >= 1.
- NOP_WORD, 32'h00000013: pad word used for Data2 when the stream has an odd word count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  DATA_W  instruction word.
- in_last  in  1  marks the final word of the program.
- enable_load_ex_mem  out  1  external-memory write enable to the core.
- InstExMemAddress  out  ADDR_W  write byte address.
- InstExMemData1  out  DATA_W  word at address.
- InstExMemData2  out  DATA_W  word at address+4.
- core_reset  out  1  active-high reset pulse to the core.
- busy  out  1  high from start until DONE.
- done  out  1  sticky; load complete.
- overflow  out  1  sticky; program exceeded address space, excess words discarded.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including address, data, core_reset, done, overflow and in_ready.
- States: IDLE, GET1, GET2, WRITE, DRAIN, CORE_RST, DONE.
- IDLE / DONE:
  - On start=1 go to GET1 next cycle.
  - Clear done and overflow, set address to 0, assert busy.
- GET1:
  - in_ready=1. A transfer occurs when in_valid and in_ready are both high.
  - On transfer, latch the word into Data1.
  - If in_last: Data2 = NOP_WORD, set last_seen, go to WRITE.
  - Otherwise go to GET2.
- GET2:
  - in_ready=1. On transfer, latch the word into Data2 and go to WRITE.
  - last_seen = in_last.
- WRITE:
  - in_ready=0. enable_load_ex_mem=1 for exactly HOLD_CYCLES cycles.
  - Address and data are stable for all held cycles.
  - Exit rules, in priority order:
    - last_seen: go to CORE_RST.
    - Address == 2^ADDR_W - ADDR_STEP (9'h1F8): go to DRAIN and set overflow.
    - Otherwise: address += ADDR_STEP, go to GET1.
  - Address never wraps.
- enable_load_ex_mem is 0 in every state except WRITE. Data/address outputs keep their last values outside WRITE.
- DRAIN: in_ready=1; discard words until a transfer with in_last, then go to DONE. No core_reset pulse is issued.
- CORE_RST: core_reset=1 for RST_CYCLES cycles, then go to DONE.
- DONE: done=1, busy=0.
- start is ignored while busy. Stream words are never accepted in IDLE or DONE.
- Latency: from the transfer of the second word of a pair, enable_load_ex_mem rises on the next cycle.
- Reset mid-operation: immediate return to IDLE with outputs zeroed. A partial pair is never written.

Decomposition:
- Shared package imem_loader_pkg holds:
  - State enum type.
  - NOP_WORD constant.
  - Default ADDR_STEP, HOLD_CYCLES and RST_CYCLES constants.
- A single down-counter is shared between the WRITE hold and the CORE_RST pulse. It stays inline; no sub-module is needed.

Test Plan:
- Program of 8 words (0x00100393, 0x00400113, 0x00010233, 0x00038303, 0x00020333, 0x00030383, 0x00031403, 0x00032483) with in_valid always 1 -> four writes at addresses 0x000, 0x008, 0x010, 0x018, each with enable held 2 cycles and the correct Data1/Data2; then core_reset for 1 cycle; done=1; overflow=0.
- Odd program of 3 words -> second write at 0x008 carries Data1=word3 and Data2=0x00000013.
- Random in_valid gaps on the same program -> identical write sequence; no write issued with a half-filled pair; in_ready=0 throughout WRITE.
- 130-word stream -> 64 writes ending at 0x1F8, then remaining words drained up to in_last; overflow=1; no core_reset pulse; done=1.
- start pulsed during WRITE -> ignored. Reset asserted mid-GET2 -> all outputs 0 immediately. A new start reloads from 0x000.
- Second start from DONE -> done and overflow cleared, address restarts at 0x000.
